// File: rtl/dac_pkg.sv
// Shared DAC definitions: sample width, sample type, midscale code and the
// trigger FSM state encoding used by the pacer.
package dac_pkg;

   localparam int DAC_BITS = 12;

   typedef logic [DAC_BITS-1:0] dac_sample_t;

   // Midscale code; also used by the DAC driver and the NCO.
   localparam dac_sample_t DAC_MIDSCALE = 12'h800;

   typedef enum logic {
      TRIG_IDLE  = 1'b0,
      TRIG_PULSE = 1'b1
   } trig_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count.
// Ports:
//   CLK, RST  clock and synchronous active-high reset (empties the FIFO)
//   push      write wdata (ignored while full)
//   pop       advance the read pointer (ignored while empty)
//   wdata     write data
//   rdata     head of the FIFO (valid while not empty)
//   full      level == 2**DEPTH_LOG2
//   empty     level == 0
//   level     occupancy, 0..2**DEPTH_LOG2
module sync_fifo #(
   parameter int WIDTH      = 12,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  push,
   input  logic                  pop,
   input  logic [WIDTH-1:0]      wdata,
   output logic [WIDTH-1:0]      rdata,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   level
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   assign full    = (level == (DEPTH_LOG2+1)'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Storage carries no reset; only pointers and level define contents.
   always_ff @(posedge CLK) begin
      if (!RST && do_push) mem[wr_ptr] <= wdata;
   end

   // Pointers are DEPTH_LOG2 bits wide and wrap naturally.
   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/dac_sample_pacer.sv
// Paces 12-bit samples from a bursty producer out to the SPI DAC driver at a
// fixed rate: one release every PERIOD clocks, each with a TRIG_WIDTH-clock
// trigger pulse whose rising edge coincides with the new data.
// Ports:
//   CLK, RST        clock and synchronous active-high reset
//   i_enable        run the period timer / allow releases
//   i_data,i_valid  producer sample and valid
//   o_ready         FIFO can accept (push = i_valid & o_ready)
//   o_dac_data      sample to DAC driver, held between releases
//   o_dac_trig      release pulse to DAC driver
//   o_level         FIFO occupancy
//   o_underrun      sticky: a release found the FIFO empty
//   i_clr_underrun  clears o_underrun (a new underrun on the same cycle wins)
module dac_sample_pacer
   import dac_pkg::*;
#(
   parameter int                  PERIOD     = 1000,
   parameter int                  DEPTH_LOG2 = 4,
   parameter int                  TRIG_WIDTH = 2,
   parameter logic [DAC_BITS-1:0] RESET_CODE = DAC_MIDSCALE
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  i_enable,
   input  logic [DAC_BITS-1:0]   i_data,
   input  logic                  i_valid,
   output logic                  o_ready,
   output logic [DAC_BITS-1:0]   o_dac_data,
   output logic                  o_dac_trig,
   output logic [DEPTH_LOG2:0]   o_level,
   output logic                  o_underrun,
   input  logic                  i_clr_underrun
);

   localparam int TW = $clog2(PERIOD);
   localparam int CW = (TRIG_WIDTH > 1) ? $clog2(TRIG_WIDTH) : 1;

   logic [TW-1:0] timer;
   logic          tick;
   logic          fifo_full;
   logic          fifo_empty;
   dac_sample_t   head;
   logic          push;
   logic          pop;
   trig_state_t   state;
   trig_state_t   next_state;
   logic [CW-1:0] wcnt;
   logic [CW-1:0] next_wcnt;

   assign tick    = i_enable && (timer == TW'(PERIOD - 1));
   assign o_ready = !fifo_full;
   assign push    = i_valid && o_ready;
   // Pop sees the pre-edge empty flag, so a sample pushed on a tick cycle
   // into an empty FIFO waits for the next tick.
   assign pop     = tick && !fifo_empty;

   sync_fifo #(
      .WIDTH      (DAC_BITS),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .CLK   (CLK),
      .RST   (RST),
      .push  (push),
      .pop   (pop),
      .wdata (i_data),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (o_level)
   );

   // Period timer: runs 0..PERIOD-1 while enabled, parked at 0 otherwise.
   always_ff @(posedge CLK) begin
      if (RST || !i_enable)               timer <= '0;
      else if (timer == TW'(PERIOD - 1))  timer <= '0;
      else                                timer <= timer + 1'b1;
   end

   // Data and trigger state update on the same edge, so the trigger's rising
   // edge always lands with the new (or held) sample already on o_dac_data.
   always_ff @(posedge CLK) begin
      if (RST)      o_dac_data <= RESET_CODE;
      else if (pop) o_dac_data <= head;
   end

   always_ff @(posedge CLK) begin
      if (RST)                      o_underrun <= 1'b0;
      else if (tick && fifo_empty)  o_underrun <= 1'b1;
      else if (i_clr_underrun)      o_underrun <= 1'b0;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= TRIG_IDLE;
         wcnt  <= '0;
      end else begin
         state <= next_state;
         wcnt  <= next_wcnt;
      end
   end

   // Pulse length depends only on the width counter, so dropping i_enable
   // mid-pulse does not shorten it.
   always_comb begin
      next_state = state;
      next_wcnt  = wcnt;
      case (state)
         TRIG_IDLE: begin
            if (tick) begin
               next_state = TRIG_PULSE;
               next_wcnt  = CW'(TRIG_WIDTH - 1);
            end
         end
         TRIG_PULSE: begin
            if (wcnt == '0) next_state = TRIG_IDLE;
            else            next_wcnt  = wcnt - CW'(1);
         end
         default: next_state = TRIG_IDLE;
      endcase
   end

   assign o_dac_trig = (state == TRIG_PULSE);

endmodule

// File: tb/tb_dac_sample_pacer.sv
module tb_dac_sample_pacer;

   localparam int PERIOD = 10;
   localparam int DLOG   = 2;
   localparam int DEPTH  = 1 << DLOG;
   localparam int TRIG_W = 2;

   logic          CLK = 1'b0;
   logic          RST;
   logic          i_enable;
   logic [11:0]   i_data;
   logic          i_valid;
   logic          o_ready;
   logic [11:0]   o_dac_data;
   logic          o_dac_trig;
   logic [DLOG:0] o_level;
   logic          o_underrun;
   logic          i_clr_underrun;

   dac_sample_pacer #(
      .PERIOD     (PERIOD),
      .DEPTH_LOG2 (DLOG),
      .TRIG_WIDTH (TRIG_W),
      .RESET_CODE (12'h800)
   ) dut (
      .CLK            (CLK),
      .RST            (RST),
      .i_enable       (i_enable),
      .i_data         (i_data),
      .i_valid        (i_valid),
      .o_ready        (o_ready),
      .o_dac_data     (o_dac_data),
      .o_dac_trig     (o_dac_trig),
      .o_level        (o_level),
      .o_underrun     (o_underrun),
      .i_clr_underrun (i_clr_underrun)
   );

   always #5 CLK = ~CLK;

   int tests = 0;
   int fails = 0;

   function automatic void chk(string name, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference model: sample queue, held output, sticky flag, remaining
   // trigger-high cycles and elapsed clocks in the current period.
   typedef struct { logic [11:0] data; logic under; } exp_t;
   exp_t        exp_q[$];
   logic [11:0] m_q[$];
   logic [11:0] m_last  = 12'h800;
   bit          m_under = 1'b0;
   int          m_pulse = 0;
   int          m_timer = 0;
   bit          m_live  = 1'b0;
   bit          m_tick;
   bit          m_accept;

   always @(posedge CLK) begin
      if (RST) begin
         m_q.delete();
         exp_q.delete();
         m_last  = 12'h800;
         m_under = 1'b0;
         m_pulse = 0;
         m_timer = 0;
         m_live  = 1'b1;
      end else if (m_live) begin
         m_tick   = i_enable && (m_timer == PERIOD - 1);
         m_accept = i_valid && (m_q.size() < DEPTH);
         if (m_pulse > 0) m_pulse--;
         if (m_tick && m_q.size() == 0) m_under = 1'b1;
         else if (i_clr_underrun)       m_under = 1'b0;
         if (m_tick) begin
            m_pulse = TRIG_W;
            if (m_q.size() > 0) m_last = m_q.pop_front();
         end
         if (m_accept) m_q.push_back(i_data);
         if (m_tick) exp_q.push_back('{m_last, m_under});
         m_timer = !i_enable ? 0 : (m_timer == PERIOD - 1) ? 0 : m_timer + 1;
      end
   end

   // Monitor: per-cycle state checks plus scoreboard pop on each trigger rise.
   bit   prev_trig = 1'b0;
   exp_t e;
   always @(negedge CLK) begin
      if (m_live) begin
         chk("level", int'(o_level), m_q.size());
         chk("ready", int'(o_ready), int'(m_q.size() != DEPTH));
         chk("trig",  int'(o_dac_trig), int'(m_pulse > 0));
         chk("data_hold", int'(o_dac_data), int'(m_last));
         chk("underrun", int'(o_underrun), int'(m_under));
         if (o_dac_trig && !prev_trig) begin
            if (exp_q.size() == 0) begin
               chk("sb_unexpected_trig", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("sb_release_data", int'(o_dac_data), int'(e.data));
               chk("sb_release_under", int'(o_underrun), int'(e.under));
            end
         end
         prev_trig = o_dac_trig;
      end
   end

   task automatic cyc(int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic push1(logic [11:0] v);
      i_data  = v;
      i_valid = 1'b1;
      cyc(1);
      i_valid = 1'b0;
   endtask

   task automatic wait_trig();
      bit seen = 1'b0;
      for (int k = 0; k < 3 * PERIOD && !seen; k++) begin
         cyc(1);
         seen = o_dac_trig;
      end
      chk("wait_trig_timeout", int'(seen), 1);
   endtask

   initial begin
      RST = 1'b1; i_enable = 1'b0; i_data = '0; i_valid = 1'b0; i_clr_underrun = 1'b0;
      cyc(3);
      RST = 1'b0;
      // Idle: nothing released while disabled.
      cyc(5000);

      // Paced release of three samples, followed by underruns.
      push1(12'h123); push1(12'h456); push1(12'h789);
      i_enable = 1'b1;
      cyc(45);
      i_clr_underrun = 1'b1; cyc(1); i_clr_underrun = 1'b0;
      cyc(3);
      // Clear held across new underruns: set must win.
      i_clr_underrun = 1'b1; cyc(25); i_clr_underrun = 1'b0;

      // Fill to full while disabled, then release with continuous pushes.
      i_enable = 1'b0;
      cyc(1);
      i_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin i_data = 12'($urandom); cyc(1); end
      i_enable = 1'b1;
      for (int k = 0; k < 30; k++) begin i_data = 12'($urandom); cyc(1); end
      i_valid = 1'b0;
      cyc(50);

      // Randomised traffic.
      for (int k = 0; k < 3000; k++) begin
         i_valid        = ($urandom_range(0, 7) == 0);
         i_data         = 12'($urandom);
         i_clr_underrun = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 199) == 0) i_enable = ~i_enable;
         RST            = ($urandom_range(0, 999) == 0);
         cyc(1);
      end
      RST = 1'b0; i_valid = 1'b0; i_clr_underrun = 1'b0;

      // Drop enable in the middle of a pulse.
      i_enable = 1'b1;
      push1(12'hABC);
      wait_trig();
      i_enable = 1'b0;
      cyc(30);

      // Reset in the middle of a pulse.
      i_enable = 1'b1;
      push1(12'h321); push1(12'h654);
      wait_trig();
      RST = 1'b1; cyc(1); RST = 1'b0;
      cyc(25);

      i_enable = 1'b0;
      cyc(5);
      chk("sb_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
